// File: rtl/inst_fetch_stage.sv
// ---------------------------------------------------------------------------
// inst_fetch_stage
//
// Instruction-fetch front end sitting directly upstream of the I-cache.
// Holds the program counter and keeps at most one fetch outstanding. The
// returned word is buffered and presented to decode, tagged with its PC.
// Execute may redirect the PC in any cycle. A response that belongs to a
// fetch made before the redirect is dropped and never reaches decode.
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   defined   -> fetch_cnt counts delivered instructions. stall_cnt counts
//                every cycle in which no instruction is delivered.
//   undefined -> both counters are tied to zero. The port list is the same.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    synchronous active-high reset
//   to_icache_req_valid    fetch request valid (only in REQ)
//   to_icache_req_addr     fetch address, word aligned
//   from_icache_req_ready  cache accepts the request
//   from_icache_rsp_valid  cache returns an instruction word
//   from_icache_rsp_data   instruction word
//   to_icache_rsp_ready    fetch stage accepts the word (only in WAIT_RSP)
//   to_dec_valid           buffered instruction valid to decode
//   to_dec_inst            buffered instruction
//   to_dec_pc              PC of to_dec_inst
//   from_dec_ready         decode accepts the instruction
//   redirect_valid         one-cycle redirect strobe
//   redirect_pc            redirect target (bits [1:0] ignored)
//   fetch_cnt              delivered-instruction counter
//   stall_cnt              stall-cycle counter
// ---------------------------------------------------------------------------
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        to_icache_req_valid,
    output logic [31:0] to_icache_req_addr,
    input  logic        from_icache_req_ready,
    input  logic        from_icache_rsp_valid,
    input  logic [31:0] from_icache_rsp_data,
    output logic        to_icache_rsp_ready,
    output logic        to_dec_valid,
    output logic [31:0] to_dec_inst,
    output logic [31:0] to_dec_pc,
    input  logic        from_dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_REQ      = 3'b001,
        S_WAIT_RSP = 3'b010,
        S_HOLD     = 3'b100
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic [31:0] buf_pc;
    // Set while the outstanding fetch was issued for a PC that has since
    // been redirected away from; its response must be dropped.
    logic        kill;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            inst_buf <= 32'h0;
            buf_pc   <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (from_icache_req_ready) begin
                        state <= S_WAIT_RSP;
                        // The request that went out this cycle carried the
                        // old PC, so a simultaneous redirect makes it stale.
                        kill  <= redirect_valid;
                    end
                end
                S_WAIT_RSP: begin
                    if (redirect_valid) pc <= redirect_tgt;
                    if (from_icache_rsp_valid) begin
                        kill <= 1'b0;
                        if (kill || redirect_valid) begin
                            state <= S_REQ;
                        end else begin
                            inst_buf <= from_icache_rsp_data;
                            buf_pc   <= pc;
                            state    <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect wins over the sequential +4, even when decode
                    // takes the buffered instruction in the same cycle.
                    if (redirect_valid) begin
                        pc    <= redirect_tgt;
                        state <= S_REQ;
                    end else if (from_dec_ready) begin
                        pc    <= pc + 32'd4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Outputs decode only registered state, so they change on clock edges only.
    assign to_icache_req_valid = (state == S_REQ);
    assign to_icache_req_addr  = pc;
    assign to_icache_rsp_ready = (state == S_WAIT_RSP);
    assign to_dec_valid        = (state == S_HOLD);
    assign to_dec_inst         = (state == S_HOLD) ? inst_buf : 32'h0;
    assign to_dec_pc           = (state == S_HOLD) ? buf_pc : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (to_dec_valid && from_dec_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            else                                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'h0;
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_stage
//
// Randomized bench for inst_fetch_stage. The bench plays the I-cache, decode
// and execute. It tracks the fetch at transaction level: the next expected
// fetch address, whether a fetch is outstanding, whether that fetch went
// stale because of a redirect, and which instruction decode is offered.
// Cache data is a fixed function of the address, so every delivered word
// can be checked against the PC it was delivered with.
// ---------------------------------------------------------------------------
module tb_inst_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int          CYCLES = 4000;

    logic        clk;
    logic        rst;
    logic        to_icache_req_valid;
    logic [31:0] to_icache_req_addr;
    logic        from_icache_req_ready;
    logic        from_icache_rsp_valid;
    logic [31:0] from_icache_rsp_data;
    logic        to_icache_rsp_ready;
    logic        to_dec_valid;
    logic [31:0] to_dec_inst;
    logic [31:0] to_dec_pc;
    logic        from_dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    inst_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .to_icache_req_valid   (to_icache_req_valid),
        .to_icache_req_addr    (to_icache_req_addr),
        .from_icache_req_ready (from_icache_req_ready),
        .from_icache_rsp_valid (from_icache_rsp_valid),
        .from_icache_rsp_data  (from_icache_rsp_data),
        .to_icache_rsp_ready   (to_icache_rsp_ready),
        .to_dec_valid          (to_dec_valid),
        .to_dec_inst           (to_dec_inst),
        .to_dec_pc             (to_dec_pc),
        .from_dec_ready        (from_dec_ready),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .fetch_cnt             (fetch_cnt),
        .stall_cnt             (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Transaction-level reference state
    logic [31:0] exp_pc;      // address the next request must carry
    logic        outstanding; // request accepted, response not yet returned
    logic [31:0] out_addr;    // address of the outstanding request
    logic        stale;       // outstanding fetch superseded by a redirect
    logic        holding;     // instruction offered to decode
    logic [31:0] hold_pc;
    int          n_deliv;
    int          n_stall;
    int          n_total_deliv;
    int          n_wrap;
    logic [31:0] tgt;

    task automatic model_reset();
        exp_pc      = RST_PC;
        outstanding = 1'b0;
        out_addr    = 32'h0;
        stale       = 1'b0;
        holding     = 1'b0;
        hold_pc     = 32'h0;
        n_deliv     = 0;
        n_stall     = 0;
    endtask

    initial begin
        rst                   = 1'b1;
        from_icache_req_ready = 1'b0;
        from_icache_rsp_valid = 1'b0;
        from_icache_rsp_data  = 32'h0;
        from_dec_ready        = 1'b0;
        redirect_valid        = 1'b0;
        redirect_pc           = 32'h0;
        n_total_deliv         = 0;
        n_wrap                = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_req_valid", {31'h0, to_icache_req_valid}, 32'h1);
        chk("reset_req_addr", to_icache_req_addr, RST_PC);
        chk("reset_dec_valid", {31'h0, to_dec_valid}, 32'h0);
        chk("reset_dec_inst", to_dec_inst, 32'h0);
        chk("reset_dec_pc", to_dec_pc, 32'h0);
        chk("reset_fetch_cnt", fetch_cnt, 32'h0);
        chk("reset_stall_cnt", stall_cnt, 32'h0);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            if (cyc != 0) begin
                @(posedge clk);
                #1;
            end
            // Observe outputs against the reference state
            chk("req_valid", {31'h0, to_icache_req_valid}, {31'h0, !(outstanding || holding)});
            chk("rsp_ready", {31'h0, to_icache_rsp_ready}, {31'h0, outstanding});
            chk("dec_valid", {31'h0, to_dec_valid}, {31'h0, holding});
            if (!(outstanding || holding)) chk("req_addr", to_icache_req_addr, exp_pc);
            if (holding) begin
                chk("dec_pc", to_dec_pc, hold_pc);
                chk("dec_inst", to_dec_inst, mem_word(hold_pc));
            end
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, n_deliv);
            chk("stall_cnt", stall_cnt, n_stall);
`else
            chk("fetch_cnt_off", fetch_cnt, 32'h0);
            chk("stall_cnt_off", stall_cnt, 32'h0);
`endif

            // Drive the next cycle's inputs
            rst                   = ($urandom_range(0, 999) == 0);
            from_icache_req_ready = ($urandom_range(0, 2) != 0);
            from_icache_rsp_valid = to_icache_rsp_ready && ($urandom_range(0, 2) == 0);
            from_icache_rsp_data  = stale ? 32'hDEAD_BEEF : mem_word(out_addr);
            if (!from_icache_rsp_valid) from_icache_rsp_data = $urandom;
            from_dec_ready        = ($urandom_range(0, 3) != 0);
            redirect_valid        = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = 32'h0000_2002;
                default: redirect_pc = $urandom;
            endcase
            tgt = redirect_pc & 32'hFFFF_FFFC;

            // Advance the reference by one cycle
            if (rst) begin
                model_reset();
            end else begin
                if (holding && from_dec_ready) n_deliv++;
                else                           n_stall++;
                if (to_icache_req_valid && from_icache_req_ready) begin
                    outstanding = 1'b1;
                    out_addr    = exp_pc;
                    stale       = redirect_valid;
                end else if (outstanding && from_icache_rsp_valid) begin
                    outstanding = 1'b0;
                    if (!stale && !redirect_valid) begin
                        holding = 1'b1;
                        hold_pc = out_addr;
                    end
                    stale = 1'b0;
                end else if (outstanding && redirect_valid) begin
                    stale = 1'b1;
                end else if (holding) begin
                    if (from_dec_ready) begin
                        n_total_deliv++;
                        if (hold_pc == 32'hFFFF_FFFC && !redirect_valid) n_wrap++;
                        holding = 1'b0;
                        exp_pc  = hold_pc + 32'd4;
                    end
                    if (redirect_valid) holding = 1'b0;
                end
                if (redirect_valid) exp_pc = tgt;
            end
        end

        // Make sure the random run actually moved instructions through
        chk("some_delivered", {31'h0, (n_total_deliv > 100)}, 32'h1);
        chk("wrap_seen", {31'h0, (n_wrap > 0)}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- CPU-side front end that sits directly upstream of the instruction cache.
- Holds the program counter and issues one 4-byte-aligned fetch request at a time on the cache request channel.
- Accepts the returned instruction and presents it, tagged with its PC, to the decode stage over a valid/ready handshake.
- Accepts branch/jump redirects at any time; any stale in-flight instruction is discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- to_icache_req_valid  output  1  fetch request valid
- to_icache_req_addr  output  32  fetch address, bits [1:0] always 0
- from_icache_req_ready  input  1  cache accepts request
- from_icache_rsp_valid  input  1  cache instruction valid
- from_icache_rsp_data  input  32  instruction word
- to_icache_rsp_ready  output  1  fetch stage accepts instruction
- to_dec_valid  output  1  instruction valid to decode
- to_dec_inst  output  32  instruction
- to_dec_pc  output  32  PC of to_dec_inst
- from_dec_ready  input  1  decode accepts instruction
- redirect_valid  input  1  one-cycle redirect strobe from execute
- redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0
- fetch_cnt  output  32  delivered-instruction counter (see Optional Feature)
- stall_cnt  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- State machine, one-hot: REQ, WAIT_RSP, HOLD.
- Reset: state=REQ, pc=RESET_PC, kill=0, inst_buf=0. Outputs the cycle after rst deasserts: to_icache_req_valid=1, to_icache_req_addr=RESET_PC, to_icache_rsp_ready=0, to_dec_valid=0, to_dec_inst=0, to_dec_pc=0. Counters=0.
- REQ:
  - to_icache_req_valid=1, to_icache_req_addr=pc.
  - On valid&ready, go to WAIT_RSP.
  - req_addr changes while valid only on redirect.
- WAIT_RSP:
  - to_icache_rsp_ready=1.
  - On rsp_valid with kill=0: inst_buf<=data, buf_pc<=pc, go to HOLD.
  - On rsp_valid with kill=1: drop the word, clear kill, go to REQ (pc already holds the redirect target).
- HOLD:
  - to_dec_valid=1, to_dec_inst=inst_buf, to_dec_pc=buf_pc; both held stable until accepted.
  - On from_dec_ready: pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), go to REQ.
- Latency: request accept to rsp_valid is cache-defined. rsp accept to to_dec_valid is 1 cycle. Decode accept to next req_valid is 1 cycle. Only one fetch is outstanding at a time.
- Redirect, highest priority, evaluated every cycle:
  - In REQ: pc<=redirect_pc. If the current request is accepted in the same cycle, set kill=1 and go to WAIT_RSP.
  - In WAIT_RSP: pc<=redirect_pc, kill<=1. If rsp_valid arrives in the same cycle, drop it, clear kill, go to REQ.
  - In HOLD: discard the buffer, to_dec_valid drops the next cycle, pc<=redirect_pc, go to REQ. If from_dec_ready is high in the same cycle, the handshake still counts as delivered, but pc takes redirect_pc, not +4.
  - Back-to-back redirects: the latest target wins; kill stays 1 until the stale response has been dropped.
- Reset mid-operation: the instruction cache shares rst, so any outstanding transaction is abandoned. All state returns to reset values with no draining.
- to_icache_rsp_ready is 0 outside WAIT_RSP. to_icache_req_valid is 0 outside REQ.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on each to_dec_valid&from_dec_ready.
  - stall_cnt increments every cycle state!=HOLD, or state==HOLD with from_dec_ready=0.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: counter logic is omitted; fetch_cnt and stall_cnt are tied to 32'h0. The port list is identical in both builds.

Test Plan:
- Reset with RESET_PC=32'h0000_1000; cache returns after 2 cycles, decode always ready -> requests to 0x1000, 0x1004, 0x1008 in order; to_dec_pc matches each address; to_dec_inst equals cache data.
- Decode ready held low for 5 cycles in HOLD -> to_dec_valid/inst/pc stable for all 5 cycles; no new request issued; pc advances by 4 only after ready.
- Redirect to 32'h0000_2002 while in WAIT_RSP; cache then returns 32'hDEAD_BEEF -> word dropped, never presented to decode; next request addr=0x2000.
- Redirect in HOLD in the same cycle as from_dec_ready -> that instruction counts as delivered; next request addr = redirect target, not pc+4.
- pc=32'hFFFF_FFFC delivered -> next request addr=0x0000_0000.
- FETCH_PERF_CNT_EN defined: 10 instructions delivered with 3 decode-stall cycles -> fetch_cnt=10, stall_cnt = 3 + all REQ/WAIT_RSP cycles. Undefined: both counters stay 0.
